// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle MIPS core: word RAM plus an MMIO
// block holding a cycle counter, a GPIO output register and a byte TX FIFO.
module dmem_responder #(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);

  localparam logic [13:0] OFF_CYCLE  = 14'd0;
  localparam logic [13:0] OFF_GPIO   = 14'd1;
  localparam logic [13:0] OFF_TXDATA = 14'd2;
  localparam logic [13:0] OFF_STATUS = 14'd3;
  localparam logic [7:0]  DEPTH8     = 8'(FIFO_DEPTH);

  logic [31:0]   r_mem [MEM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [31:0]   r_cycle;
  logic [7:0]    r_gpio;
  logic [FW-1:0] r_rd_ptr;
  logic [FW-1:0] r_wr_ptr;
  logic [7:0]    r_count;
  logic          r_ovf;

  logic          w_mmio;
  logic [13:0]   w_word_off;
  logic [AW-1:0] w_ram_idx;
  logic          w_ram_wr;
  logic          w_gpio_wr;
  logic          w_tx_wr;
  logic          w_stat_wr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic [31:0]   w_status;
  logic          w_unused;

  // Byte lane bits are don't-care for this word-only port.
  assign w_unused   = &{1'b0, addr[1:0]};

  assign w_mmio     = (addr[31:16] == 16'hFFFF);
  assign w_word_off = addr[15:2];
  assign w_ram_idx  = addr[AW+1:2];

  assign w_ram_wr   = memwrite & ~w_mmio;
  assign w_gpio_wr  = memwrite & w_mmio & (w_word_off == OFF_GPIO);
  assign w_tx_wr    = memwrite & w_mmio & (w_word_off == OFF_TXDATA);
  assign w_stat_wr  = memwrite & w_mmio & (w_word_off == OFF_STATUS);

  assign w_empty    = (r_count == 8'd0);
  assign w_full     = (r_count == DEPTH8);
  assign w_pop      = ~w_empty & tx_ready;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_push     = w_tx_wr & (~w_full | w_pop);
  assign w_ovf_set  = w_tx_wr & w_full & ~w_pop;

  assign w_status   = {16'h0000, r_count, 5'b00000, r_ovf, w_full, w_empty};

  assign gpio_out   = r_gpio;
  assign tx_valid   = ~w_empty;
  assign tx_data    = r_fifo[r_rd_ptr];

  // Word RAM storage; contents survive reset, stores are blocked during it.
  always_ff @(posedge clk) begin
    if (reset && w_ram_wr) begin
      r_mem[w_ram_idx] <= writedata;
    end
  end

  // TX FIFO byte storage.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_fifo[r_wr_ptr] <= writedata[7:0];
    end
  end

  // Counter, GPIO, FIFO pointers/count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle  <= 32'd0;
      r_gpio   <= 8'd0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 8'd0;
      r_ovf    <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_gpio_wr) begin
        r_gpio <= writedata[7:0];
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FW'(1'b1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FW'(1'b1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 8'd1;
        2'b01:   r_count <= r_count - 8'd1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_stat_wr && writedata[2]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Combinational load path demanded by the single-cycle core.
  always_comb begin
    readdata = 32'h0000_0000;
    if (w_mmio) begin
      case (w_word_off)
        OFF_CYCLE:  readdata = r_cycle;
        OFF_GPIO:   readdata = {24'h00_0000, r_gpio};
        OFF_TXDATA: readdata = 32'h0000_0000;
        OFF_STATUS: readdata = w_status;
        default:    readdata = 32'h0000_0000;
      endcase
    end else begin
      readdata = r_mem[w_ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios followed by random
// traffic, checked against a transaction-level model of the memory map.
module tb_dmem_responder;

  localparam int MEM_WORDS  = 64;
  localparam int FIFO_DEPTH = 4;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam int NC = 0;  // no read check
  localparam int MD = 1;  // expect value from model
  localparam int CK = 2;  // expect explicit constant

  localparam logic [31:0] A_CYC  = 32'hFFFF_0000;
  localparam logic [31:0] A_GPIO = 32'hFFFF_0004;
  localparam logic [31:0] A_TXD  = 32'hFFFF_0008;
  localparam logic [31:0] A_STAT = 32'hFFFF_000C;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  dmem_responder #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .gpio_out(gpio_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] exp; } rd_t;
  rd_t        rd_q[$];
  logic [7:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_ram [MEM_WORDS];
  bit          m_known [MEM_WORDS];
  logic [31:0] m_cyc   = 32'd0;
  logic [7:0]  m_gpio  = 8'd0;
  int          m_count = 0;
  bit          m_ovf   = 1'b0;
  bit          mon_en  = 1'b0;

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:16] == 16'hFFFF;
  endfunction

  function automatic int ram_index(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  function automatic bit known(input logic [31:0] a);
    return is_mmio(a) || m_known[ram_index(a)];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int off;
    off = int'(a[15:0]) / 4;
    if (!is_mmio(a)) return m_ram[ram_index(a)];
    if (off == 0) return m_cyc;
    if (off == 1) return {24'h000000, m_gpio};
    if (off == 3) return {16'h0000, 8'(m_count), 5'b00000, m_ovf,
                          (m_count == FIFO_DEPTH), (m_count == 0)};
    return 32'h0000_0000;
  endfunction

  // Reference model: applies each cycle's store and handshake at the edge.
  initial forever begin
    int cnt0;
    bit pop;
    int idx;
    @(posedge clk);
    if (!reset) begin
      m_cyc = 32'd0; m_gpio = 8'd0; m_count = 0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      m_cyc = m_cyc + 32'd1;
      cnt0 = m_count;
      pop = (cnt0 != 0) && tx_ready;
      if (pop) m_count = m_count - 1;
      if (memwrite) begin
        if (is_mmio(addr)) begin
          case (int'(addr[15:0]) / 4)
            1: m_gpio = writedata[7:0];
            2: begin
              if (cnt0 < FIFO_DEPTH || pop) begin
                exp_q.push_back(writedata[7:0]);
                m_count = m_count + 1;
              end else begin
                m_ovf = 1'b1;
              end
            end
            3: if (writedata[2]) m_ovf = 1'b0;
            default: ;
          endcase
        end else begin
          idx = ram_index(addr);
          m_ram[idx] = writedata;
          m_known[idx] = 1'b1;
        end
      end
    end
  end

  // Monitor: compares every presented output against the scoreboard.
  initial forever begin
    rd_t r;
    @(negedge clk);
    if (mon_en) begin
      n_cmp++;
      if (tx_valid !== (m_count != 0)) begin
        n_err++;
        $display("FAIL tx_valid: got %b, expected %b", tx_valid, (m_count != 0));
      end
      n_cmp++;
      if (gpio_out !== m_gpio) begin
        n_err++;
        $display("FAIL gpio_out: got %h, expected %h", gpio_out, m_gpio);
      end
      if (tx_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL tx_data: got %h, expected no byte pending", tx_data);
        end else begin
          if (tx_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL tx_data: got %h, expected %h", tx_data, exp_q[0]);
          end
          if (tx_ready) void'(exp_q.pop_front());
        end
      end
      while (rd_q.size() > 0) begin
        r = rd_q.pop_front();
        n_cmp++;
        if (readdata !== r.exp) begin
          n_err++;
          $display("FAIL readdata @%h: got %h, expected %h", r.a, readdata, r.exp);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic rdy, input int mode,
                      input logic [31:0] ex);
    reset = rst; memwrite = we; addr = a; writedata = wd; tx_ready = rdy;
    if (mode == MD && known(a)) rd_q.push_back('{a, model_read(a)});
    if (mode == CK) rd_q.push_back('{a, ex});
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3);
    step(H, H, A_TXD, b0, L, NC, 32'h0);
    step(H, H, A_TXD, b1, L, NC, 32'h0);
    step(H, H, A_TXD, b2, L, NC, 32'h0);
    step(H, H, A_TXD, b3, L, NC, 32'h0);
  endtask

  initial begin
    reset = 1'b0; memwrite = 1'b0; addr = 32'h0; writedata = 32'h0; tx_ready = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset state; then counter reaches 10 ten cycles after release.
    step(L, L, A_CYC,  32'h0, L, CK, 32'h0);
    step(L, L, A_STAT, 32'h0, L, CK, 32'h0000_0001);
    step(L, L, A_GPIO, 32'h0, L, CK, 32'h0);
    repeat (10) step(H, L, 32'h0, 32'h0, L, NC, 32'h0);
    step(H, L, A_CYC, 32'h0, L, CK, 32'd10);

    // RAM store, alias, read-during-write, ignored low address bits.
    step(H, H, 32'h0000_0010, 32'hDEAD_BEEF, L, NC, 32'h0);
    step(H, L, 32'h0000_0010, 32'h0, L, CK, 32'hDEAD_BEEF);
    step(H, L, 32'h0000_0110, 32'h0, L, CK, 32'hDEAD_BEEF);
    step(H, H, 32'h0000_0010, 32'h1234_5678, L, CK, 32'hDEAD_BEEF);
    step(H, L, 32'h0000_0013, 32'h0, L, CK, 32'h1234_5678);
    step(H, H, 32'h0000_0010, 32'hDEAD_BEEF, L, NC, 32'h0);

    // Stores to CYCLE are ignored.
    step(H, H, A_CYC, 32'h0000_0000, L, MD, 32'h0);
    step(H, L, A_CYC, 32'h0, L, MD, 32'h0);

    // GPIO load and readback.
    step(H, H, A_GPIO, 32'h1234_56A5, L, NC, 32'h0);
    step(H, L, A_GPIO, 32'h0, L, CK, 32'h0000_00A5);

    // Fill, overflow, clear.
    push_bytes(32'h11, 32'h22, 32'h33, 32'h44);
    step(H, L, A_STAT, 32'h0, L, CK, 32'h0000_0402);
    step(H, H, A_TXD, 32'h55, L, NC, 32'h0);
    step(H, L, A_STAT, 32'h0, L, CK, 32'h0000_0406);
    step(H, H, A_STAT, 32'h4, L, NC, 32'h0);
    step(H, L, A_STAT, 32'h0, L, CK, 32'h0000_0402);
    step(H, L, A_TXD,  32'h0, L, CK, 32'h0);
    repeat (4) step(H, L, 32'h0, 32'h0, H, NC, 32'h0);
    step(H, L, A_STAT, 32'h0, H, CK, 32'h0000_0001);

    // Push into a full FIFO while it pops.
    push_bytes(32'h11, 32'h22, 32'h33, 32'h44);
    step(H, H, A_TXD, 32'h66, H, NC, 32'h0);
    step(H, L, A_STAT, 32'h0, L, CK, 32'h0000_0402);
    repeat (4) step(H, L, 32'h0, 32'h0, H, NC, 32'h0);
    step(H, L, A_STAT, 32'h0, L, CK, 32'h0000_0001);

    // Push into an empty FIFO: visible only on the following cycle.
    step(H, H, A_TXD, 32'h77, H, NC, 32'h0);
    step(H, L, A_STAT, 32'h0, H, CK, 32'h0000_0100);
    step(H, L, A_STAT, 32'h0, L, CK, 32'h0000_0001);

    // Reset mid-run: counter and GPIO clear, RAM kept, store ignored.
    step(L, H, 32'h0000_0010, 32'h0000_0055, H, NC, 32'h0);
    step(H, L, A_CYC,  32'h0, L, CK, 32'h0);
    step(H, L, A_GPIO, 32'h0, L, CK, 32'h0);
    step(H, L, 32'h0000_0010, 32'h0, L, CK, 32'hDEAD_BEEF);

    // Random traffic over both regions.
    for (int i = 0; i < 3000; i++) begin
      logic rst;
      logic we;
      logic rdy;
      logic [31:0] a;
      logic [31:0] wd;
      int k;
      rst = ($urandom_range(0, 399) != 0);
      rdy = ($urandom_range(0, 99) < (((i / 500) % 2 == 1) ? 80 : 20));
      k   = $urandom_range(0, 9);
      wd  = $urandom;
      a   = {1'b0, 31'($urandom)};
      we  = (k <= 1) || (k >= 4 && k <= 6);
      if (k == 4) a = {16'hFFFF, 16'h0008 + 16'($urandom_range(0, 3))};
      else if (k >= 5) a = {16'hFFFF, 16'($urandom_range(0, 5) * 4 + $urandom_range(0, 3))};
      step(rst, we, a, wd, rdy, MD, 32'h0);
    end

    repeat (6) step(H, L, A_STAT, 32'h0, H, MD, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
